// File: rtl/booth_control_if.sv
// rtl/booth_control_if.sv - handshake and strobe bundle between Booth controller and datapath
// Controller drives the strobes and cuenta; the datapath side returns qpar and issues inicio.
interface booth_control_if #(
  parameter int CW = 3
);
  logic          inicio;
  logic [1:0]    qpar;
  logic          CargaM;
  logic          BorraA;
  logic          CargaA;
  logic          RestaA;
  logic          CargaQ;
  logic          DesplazaQ;
  logic          DesplazaA;
  logic          ocupado;
  logic          fin;
  logic [CW-1:0] cuenta;

  modport master (
    input  inicio, qpar,
    output CargaM, BorraA, CargaA, RestaA, CargaQ, DesplazaQ, DesplazaA,
    output ocupado, fin, cuenta
  );

  modport slave (
    output inicio, qpar,
    input  CargaM, BorraA, CargaA, RestaA, CargaQ, DesplazaQ, DesplazaA,
    input  ocupado, fin, cuenta
  );
endinterface

// File: rtl/booth_control.sv
// rtl/booth_control.sv - radix-2 Booth multiplier sequencer
// Strobes decode from state alone except the add/subtract select, which follows qpar in EVAL.
module booth_control #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic            clk,
  input  logic            reset,
  booth_control_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] EVAL  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inicio) state <= LOAD;
        end
        LOAD: begin
          cnt   <= CW'(N);
          state <= EVAL;
        end
        EVAL: begin
          state <= SHIFT;
        end
        SHIFT: begin
          // cnt is at least 1 whenever SHIFT is entered, so this cannot wrap
          if (cnt != '0) cnt <= cnt - CW'(1);
          state <= (cnt == CW'(1)) ? DONE : EVAL;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.CargaM    = 1'b0;
    bus.BorraA    = 1'b0;
    bus.CargaA    = 1'b0;
    bus.RestaA    = 1'b0;
    bus.CargaQ    = 1'b0;
    bus.DesplazaQ = 1'b0;
    bus.DesplazaA = 1'b0;
    bus.fin       = 1'b0;
    case (state)
      LOAD: begin
        bus.CargaM = 1'b1;
        bus.CargaQ = 1'b1;
        bus.BorraA = 1'b1;
      end
      EVAL: begin
        // 10 starts a run of ones (subtract), 01 ends one (add)
        bus.CargaA = bus.qpar[1] ^ bus.qpar[0];
        bus.RestaA = bus.qpar[1] & ~bus.qpar[0];
      end
      SHIFT: begin
        bus.DesplazaA = 1'b1;
        bus.DesplazaQ = 1'b1;
      end
      DONE: begin
        bus.fin = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ocupado = (state != IDLE);
  assign bus.cuenta  = cnt;

endmodule

// File: tb/tb_booth_control.sv
// tb/tb_booth_control.sv - directed self-checking bench for booth_control
// Includes a small M/A/Q datapath so full products can be checked end to end.
module tb_booth_control;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  booth_control_if #(.CW(3)) bus ();

  booth_control #(.N(4), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       use_dp;
  logic [1:0] qpar_drv;
  logic [3:0] m_in;
  logic [3:0] q_in;
  logic [3:0] m_r;
  logic [4:0] a_r;
  logic [4:0] q_r;

  // A is one bit wider than M so that subtracting -8 does not overflow
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_r <= '0;
      a_r <= '0;
      q_r <= '0;
    end else begin
      if (bus.CargaM) m_r <= m_in;
      if (bus.BorraA) a_r <= '0;
      else if (bus.CargaA) a_r <= bus.RestaA ? a_r - {m_r[3], m_r} : a_r + {m_r[3], m_r};
      else if (bus.DesplazaA) a_r <= {a_r[4], a_r[4:1]};
      if (bus.CargaQ) q_r <= {q_in, 1'b0};
      else if (bus.DesplazaQ) q_r <= {a_r[0], q_r[4:1]};
    end
  end

  assign bus.qpar = use_dp ? q_r[1:0] : qpar_drv;

  logic [8:0] outs;
  assign outs = {bus.CargaM, bus.BorraA, bus.CargaA, bus.RestaA, bus.CargaQ,
                 bus.DesplazaQ, bus.DesplazaA, bus.ocupado, bus.fin};

  always @(negedge clk) begin
    #2;
    tests++;
    if ((bus.CargaQ && bus.DesplazaQ) ||
        ($countones({bus.CargaA, bus.BorraA, bus.DesplazaA}) > 1) ||
        (bus.fin && !bus.ocupado)) begin
      fails++;
      $display("FAIL invariant t=%0t outs=%b required mutually exclusive strobes", $time, outs);
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.inicio = 1'($urandom_range(0, 1));
      qpar_drv   = 2'($urandom_range(0, 3));
      #1;
      tests++;
      if (outs !== 9'b0 || bus.cuenta !== 3'd0) begin
        fails++;
        $display("FAIL reset_hold outs=%b cuenta=%0d required 0/0", outs, bus.cuenta);
      end
    end
    @(negedge clk);
    bus.inicio = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (outs !== 9'b0 || bus.cuenta !== 3'd0) begin
      fails++;
      $display("FAIL reset_release outs=%b cuenta=%0d required 0/0", outs, bus.cuenta);
    end
  endtask

  task automatic test_async_reset();
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (outs !== 9'b000001110) begin
      fails++;
      $display("FAIL async_pre_shift outs=%b required 000001110", outs);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (outs !== 9'b0 || bus.cuenta !== 3'd0) begin
      fails++;
      $display("FAIL async_reset outs=%b cuenta=%0d required 0/0", outs, bus.cuenta);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // qseq holds the four EVAL qpar values, first one in the top bits
  task automatic run_op(input bit lockout, input logic [7:0] qseq, input string tag);
    logic [8:0] exp_o;
    logic [2:0] exp_c;
    logic [1:0] pr;
    int         shifts;
    shifts = 0;
    bus.inicio = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc > 1) @(negedge clk);
      bus.inicio = lockout && (cyc == 1 || cyc == 2 || cyc == 3 || cyc == 10);
      pr = 2'b00;
      if (cyc >= 2 && cyc <= 9 && cyc % 2 == 0) begin
        pr = qseq[7 - 2 * (cyc / 2 - 1) -: 2];
        qpar_drv = pr;
      end else begin
        qpar_drv = 2'($urandom_range(0, 3));
      end
      #1;
      exp_c = 3'd0;
      if (cyc == 1) exp_o = 9'b110010010;
      else if (cyc <= 9 && cyc % 2 == 0) begin
        exp_c = 3'(4 - (cyc - 2) / 2);
        case (pr)
          2'b10:   exp_o = 9'b001100010;
          2'b01:   exp_o = 9'b001000010;
          default: exp_o = 9'b000000010;
        endcase
      end else if (cyc <= 9) begin
        exp_c = 3'(4 - (cyc - 2) / 2);
        exp_o = 9'b000001110;
      end else if (cyc == 10) exp_o = 9'b000000011;
      else exp_o = 9'b000000000;
      if (bus.DesplazaA) shifts++;
      tests++;
      if (outs !== exp_o || bus.cuenta !== exp_c) begin
        fails++;
        $display("FAIL %s cyc=%0d outs=%b cuenta=%0d required %b/%0d",
                 tag, cyc, outs, bus.cuenta, exp_o, exp_c);
      end
    end
    bus.inicio = 1'b0;
    tests++;
    if (shifts !== 4) begin
      fails++;
      $display("FAIL %s shift_count got %0d required 4", tag, shifts);
    end
  endtask

  task automatic test_sequencing();
    run_op(1'b0, 8'b10_11_01_00, "sequence");
  endtask

  task automatic test_busy_lockout();
    run_op(1'b1, 8'b01_10_00_11, "lockout");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    bus.inicio = 1'b1;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      #1;
      exp = {cyc % 11 == 1, cyc % 11 != 0, cyc % 11 == 10};
      tests++;
      if ({bus.CargaM, bus.ocupado, bus.fin} !== exp) begin
        fails++;
        $display("FAIL back_to_back cyc=%0d load/busy/fin=%b required %b",
                 cyc, {bus.CargaM, bus.ocupado, bus.fin}, exp);
      end
    end
    bus.inicio = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multiply(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
    int  cyc;
    bit  seen;
    use_dp = 1'b1;
    m_in = m;
    q_in = q;
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 20 && !seen) begin
      #1;
      if (bus.fin) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    tests++;
    if (!seen || cyc != 10) begin
      fails++;
      $display("FAIL mult_latency m=%h q=%h fin_cycle=%0d required 10", m, q, cyc);
    end
    tests++;
    if ({a_r[3:0], q_r[4:1]} !== exp) begin
      fails++;
      $display("FAIL mult_product m=%h q=%h got %h required %h", m, q, {a_r[3:0], q_r[4:1]}, exp);
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.ocupado !== 1'b0 || bus.cuenta !== 3'd0) begin
      fails++;
      $display("FAIL mult_idle busy=%b cuenta=%0d required 0/0", bus.ocupado, bus.cuenta);
    end
    use_dp = 1'b0;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b0;
    use_dp     = 1'b0;
    qpar_drv   = 2'b00;
    m_in       = 4'h0;
    q_in       = 4'h0;
    bus.inicio = 1'b0;
    test_reset();
    test_sequencing();
    test_busy_lockout();
    test_async_reset();
    test_back_to_back();
    test_multiply(4'd3, 4'b1110, 8'hFA);
    test_multiply(4'b1000, 4'b1000, 8'h40);
    test_multiply(4'd7, 4'd0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_control.md
Name: booth_control

Overview:
Control unit for the 4-bit radix-2 Booth multiplier datapath. It sequences the multiplicand register (M), the accumulator register (A) and the multiplier register (Q, 5 bits including the Q-1 guard bit). Each iteration it inspects the low Q pair and issues add, subtract or no-op to A, then issues an arithmetic right shift of A:Q. It sits directly upstream of the Q register and drives its CargaQ and DesplazaQ inputs.

Parameters:
N, 4, operand width in bits; equals the number of Booth iterations.
CW, 3, iteration counter width; must satisfy 2^CW > N.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
inicio  input  1  start request, level-sampled in IDLE only.
qpar  input  2  {q[1], q[0]} from the Q register; q[0] is the Q-1 guard bit.
CargaM  output  1  load multiplicand into M.
BorraA  output  1  synchronous clear of A.
CargaA  output  1  load A with ALU result.
RestaA  output  1  ALU operation select: 1 = A-M, 0 = A+M. Meaningful only while CargaA=1.
CargaQ  output  1  parallel-load Q (to Q register).
DesplazaQ  output  1  shift Q right (to Q register).
DesplazaA  output  1  arithmetic shift A right; A LSB feeds the Q fromA input.
ocupado  output  1  busy: high in every state except IDLE.
fin  output  1  done pulse.
cuenta  output  CW  remaining iterations.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cuenta=0, all outputs 0. Applies immediately, including mid-operation. Datapath registers are reset by their own reset.
- Control outputs are Moore outputs, decoded from state only, except CargaA/RestaA in EVAL, which also depend on qpar.
- States and transitions:
  - IDLE: all strobes 0. If inicio=1 at a rising edge, go to LOAD. Otherwise stay.
  - LOAD: CargaM=1, CargaQ=1, BorraA=1. At the edge, cuenta<=N. Go to EVAL.
  - EVAL: qpar=2'b10 → CargaA=1, RestaA=1. qpar=2'b01 → CargaA=1, RestaA=0. qpar=2'b00 or 2'b11 → CargaA=0, RestaA=0. Always go to SHIFT; EVAL always lasts exactly 1 cycle.
  - SHIFT: DesplazaA=1, DesplazaQ=1. At the edge, cuenta<=cuenta-1. If cuenta==1 before decrement, go to DONE; otherwise go to EVAL.
  - DONE: fin=1 for exactly 1 cycle. Go to IDLE. The product {A,Q[4:1]} stays valid until the next LOAD.
- Latency is fixed and data-independent. Counting from the edge that samples inicio: LOAD 1 cycle, then N×(EVAL+SHIFT), then DONE. fin is high during cycle 2N+2; for N=4 that is cycle 10.
- inicio is ignored in every state except IDLE. If inicio is held high through DONE, a new operation starts on the first IDLE edge, so IDLE lasts 1 cycle.
- Mutual exclusion invariants, checked every cycle:
  - CargaQ and DesplazaQ are never both 1.
  - CargaA, BorraA and DesplazaA are at most one-hot.
  - fin=1 implies ocupado=1 (DONE is busy).
- cuenta never underflows. It is 0 in IDLE after reset and 0 after completion.
- qpar is sampled only in EVAL. Values on other cycles have no effect.

Test Plan:
- Reset: hold reset=0 with random inputs, release → all outputs 0, cuenta=0, state IDLE. Assert reset=0 mid-SHIFT → outputs drop to 0 asynchronously, before the next clock edge.
- Sequencing with scripted qpar 10,11,01,00 across EVAL cycles → CargaA/RestaA = (1,1),(0,0),(1,0),(0,0). Exactly 4 SHIFT cycles. cuenta reads 4,3,2,1 in successive EVALs. fin high 10 cycles after inicio is sampled.
- Busy lockout: pulse inicio in LOAD, EVAL, SHIFT and DONE → no restart. The sequence is unchanged and ocupado=1 throughout.
- Back-to-back: inicio held high permanently → DONE, one IDLE cycle, then LOAD, repeating every 11 cycles.
- Integrated with the Q register, A/M registers and adder: M=3, Q=-2 (4'b1110) → {A,Q[4:1]} = 8'hFA (-6). M=-8, Q=-8 → 8'h40 (64). M=7, Q=0 → 8'h00.
- Invariant monitor active in all scenarios: the mutual exclusion rules above are never violated.
